// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
//   Purpose : drives the data-cache request/hit handshake from the EX/MEM latch,
//             resolves branches, generates stall/flush controls, and holds the
//             MEM/WB pipeline register, a sticky halt latch and a saturating
//             count of memory-stall cycles.
//   Ports   : CLK/nRST            clock, async active-low reset
//             WB_*/M_*/..._in     EX/MEM latch outputs
//             dhit/dmemload       cache completion and load data
//             dmemREN/WEN/addr/store  cache request (combinational)
//             mem_stall/branch_taken/branch_target/flush_out  pipeline control
//             wb_*                registered MEM/WB fields
//             halt_out            sticky halt
//             mem_wait_cnt        saturating count of stall cycles
module mem_stage #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       WB_MemToReg_in,
  input  logic             WB_RegWrite_in,
  input  logic             M_Branch_in,
  input  logic             M_MemRead_in,
  input  logic             M_MemWrite_in,
  input  logic             alu_zero_in,
  input  logic [31:0]      alu_output_in,
  input  logic [31:0]      adder_result_in,
  input  logic [31:0]      regfile_rdat2_in,
  input  logic [4:0]       reg_instr_in,
  input  logic [31:0]      pcn_in,
  input  logic             halt_in,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic             mem_stall,
  output logic             branch_taken,
  output logic [31:0]      branch_target,
  output logic             flush_out,
  output logic             wb_RegWrite,
  output logic [1:0]       wb_MemToReg,
  output logic [31:0]      wb_alu,
  output logic [31:0]      wb_load,
  output logic [31:0]      wb_pcn,
  output logic [4:0]       wb_wsel,
  output logic             halt_out,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              halt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wb_rw_q;
  logic [1:0]        wb_mtr_q;
  logic [31:0]       wb_alu_q, wb_load_q, wb_pcn_q;
  logic [4:0]        wb_wsel_q;

  logic              req_s;
  logic              stall_s;
  logic              load_done_s;

  // Request qualification; gating with nRST drops a request the moment reset asserts.
  assign req_s       = (M_MemRead_in | M_MemWrite_in) & ~halt_q & nRST;
  assign load_done_s = req_s & M_MemRead_in & ~M_MemWrite_in & dhit;

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: WAIT covers a multi-cycle access until dhit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_s && !dhit) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dhit) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: cache request, stall and branch resolution. A store wins over
  // a simultaneous load; a stall suppresses any branch redirect.
  always_comb begin
    dmemREN      = 1'b0;
    dmemWEN      = 1'b0;
    stall_s      = 1'b0;
    branch_taken = 1'b0;
    if (req_s) begin
      dmemWEN = M_MemWrite_in;
      dmemREN = ~M_MemWrite_in;
      stall_s = ~dhit;
    end else begin
      stall_s = 1'b0;
    end
    if (M_Branch_in && alu_zero_in && !halt_q && !stall_s) begin
      branch_taken = 1'b1;
    end else begin
      branch_taken = 1'b0;
    end
  end

  assign mem_stall     = stall_s;
  assign flush_out     = branch_taken;
  assign branch_target = adder_result_in;
  assign dmemaddr      = alu_output_in;
  assign dmemstore     = regfile_rdat2_in;

  // Sticky halt: set once the halt instruction leaves this stage unstalled.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt_q <= 1'b0;
    end else if (halt_in && !stall_s) begin
      halt_q <= 1'b1;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // MEM/WB register: frozen on halt, bubble on stall, otherwise advance.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_rw_q   <= 1'b0;
      wb_mtr_q  <= 2'b00;
      wb_alu_q  <= 32'h0000_0000;
      wb_load_q <= 32'h0000_0000;
      wb_pcn_q  <= 32'h0000_0000;
      wb_wsel_q <= 5'd0;
    end else if (halt_q) begin
      wb_rw_q <= wb_rw_q;
    end else if (stall_s) begin
      wb_rw_q <= 1'b0;
    end else begin
      wb_rw_q   <= WB_RegWrite_in;
      wb_mtr_q  <= WB_MemToReg_in;
      wb_alu_q  <= alu_output_in;
      wb_pcn_q  <= pcn_in;
      wb_wsel_q <= reg_instr_in;
      if (load_done_s) begin
        wb_load_q <= dmemload;
      end
    end
  end

  assign wb_RegWrite  = wb_rw_q;
  assign wb_MemToReg  = wb_mtr_q;
  assign wb_alu       = wb_alu_q;
  assign wb_load      = wb_load_q;
  assign wb_pcn       = wb_pcn_q;
  assign wb_wsel      = wb_wsel_q;
  assign halt_out     = halt_q;
  assign mem_wait_cnt = cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, hand-written multi-cycle
// sequences and random stimulus, all checked against a behavioural model.
module tb_mem_stage;
  logic        CLK;
  logic        nRST;
  logic [1:0]  mtr;
  logic        rw, br, rd, wr, zero, hlt, dhit;
  logic [31:0] alu, adder, rdat2, pcn, dload;
  logic [4:0]  wsel;

  logic        ren, wen, stall, bt, flush, o_rw, o_halt;
  logic [31:0] addr, store, target, o_alu, o_load, o_pcn;
  logic [1:0]  o_mtr;
  logic [4:0]  o_wsel;
  logic [31:0] o_cnt;

  logic        s4_ren, s4_wen, s4_stall, s4_bt, s4_flush, s4_rw, s4_halt;
  logic [31:0] s4_addr, s4_store, s4_target, s4_alu, s4_load, s4_pcn;
  logic [1:0]  s4_mtr;
  logic [4:0]  s4_wsel;
  logic [3:0]  s4_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic        m_halt, m_rw;
  logic [1:0]  m_mtr;
  logic [31:0] m_alu, m_load, m_pcn;
  logic [4:0]  m_wsel;
  longint      m_cnt;

  mem_stage #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .WB_MemToReg_in(mtr), .WB_RegWrite_in(rw),
    .M_Branch_in(br), .M_MemRead_in(rd), .M_MemWrite_in(wr), .alu_zero_in(zero),
    .alu_output_in(alu), .adder_result_in(adder), .regfile_rdat2_in(rdat2),
    .reg_instr_in(wsel), .pcn_in(pcn), .halt_in(hlt), .dhit(dhit), .dmemload(dload),
    .dmemREN(ren), .dmemWEN(wen), .dmemaddr(addr), .dmemstore(store),
    .mem_stall(stall), .branch_taken(bt), .branch_target(target), .flush_out(flush),
    .wb_RegWrite(o_rw), .wb_MemToReg(o_mtr), .wb_alu(o_alu), .wb_load(o_load),
    .wb_pcn(o_pcn), .wb_wsel(o_wsel), .halt_out(o_halt), .mem_wait_cnt(o_cnt));

  mem_stage #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .WB_MemToReg_in(mtr), .WB_RegWrite_in(rw),
    .M_Branch_in(br), .M_MemRead_in(rd), .M_MemWrite_in(wr), .alu_zero_in(zero),
    .alu_output_in(alu), .adder_result_in(adder), .regfile_rdat2_in(rdat2),
    .reg_instr_in(wsel), .pcn_in(pcn), .halt_in(hlt), .dhit(dhit), .dmemload(dload),
    .dmemREN(s4_ren), .dmemWEN(s4_wen), .dmemaddr(s4_addr), .dmemstore(s4_store),
    .mem_stall(s4_stall), .branch_taken(s4_bt), .branch_target(s4_target),
    .flush_out(s4_flush), .wb_RegWrite(s4_rw), .wb_MemToReg(s4_mtr), .wb_alu(s4_alu),
    .wb_load(s4_load), .wb_pcn(s4_pcn), .wb_wsel(s4_wsel), .halt_out(s4_halt),
    .mem_wait_cnt(s4_cnt));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected combinational behaviour, derived from the current inputs and model halt.
  function automatic logic e_req();
    return nRST && (rd || wr) && !m_halt;
  endfunction
  function automatic logic e_stall();
    return e_req() && !dhit;
  endfunction
  function automatic logic e_bt();
    return br && zero && !m_halt && !e_stall();
  endfunction

  // Reference model of the registered state.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_halt <= 1'b0; m_rw <= 1'b0; m_mtr <= 2'b00; m_alu <= 32'h0;
      m_load <= 32'h0; m_pcn <= 32'h0; m_wsel <= 5'd0; m_cnt <= 64'd0;
    end else begin
      if (e_stall()) m_cnt <= m_cnt + 64'd1;
      if (!m_halt) begin
        if (e_stall()) begin
          m_rw <= 1'b0;
        end else begin
          m_rw <= rw; m_mtr <= mtr; m_alu <= alu; m_pcn <= pcn; m_wsel <= wsel;
          if (rd && !wr && dhit) m_load <= dload;
        end
        if (hlt && !e_stall()) m_halt <= 1'b1;
      end
    end
  end

  task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    longint sat32;
    logic [255:0] exp_v;
    sat32 = (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt;
    cmp({tag, ".dmemREN"}, ren, e_req() && rd && !wr);
    cmp({tag, ".dmemWEN"}, wen, e_req() && wr);
    cmp({tag, ".dmemaddr"}, addr, alu);
    cmp({tag, ".dmemstore"}, store, rdat2);
    cmp({tag, ".mem_stall"}, stall, e_stall());
    cmp({tag, ".branch_taken"}, bt, e_bt());
    cmp({tag, ".flush_out"}, flush, e_bt());
    cmp({tag, ".branch_target"}, target, adder);
    cmp({tag, ".wb_RegWrite"}, o_rw, m_rw);
    cmp({tag, ".wb_MemToReg"}, o_mtr, m_mtr);
    cmp({tag, ".wb_alu"}, o_alu, m_alu);
    cmp({tag, ".wb_load"}, o_load, m_load);
    cmp({tag, ".wb_pcn"}, o_pcn, m_pcn);
    cmp({tag, ".wb_wsel"}, o_wsel, m_wsel);
    cmp({tag, ".halt_out"}, o_halt, m_halt);
    cmp({tag, ".mem_wait_cnt"}, o_cnt, sat32[31:0]);
    cmp({tag, ".cnt4"}, s4_cnt, (m_cnt > 64'd15) ? 64'd15 : m_cnt);
    exp_v = {e_req() && rd && !wr, e_req() && wr, alu, rdat2, e_stall(), e_bt(), adder,
             e_bt(), m_rw, m_mtr, m_alu, m_load, m_pcn, m_wsel, m_halt};
    cmp({tag, ".dut4_outs"},
        {s4_ren, s4_wen, s4_addr, s4_store, s4_stall, s4_bt, s4_target, s4_flush,
         s4_rw, s4_mtr, s4_alu, s4_load, s4_pcn, s4_wsel, s4_halt}, exp_v);
  endtask

  task automatic set_idle();
    mtr = 2'b00; rw = 1'b0; br = 1'b0; rd = 1'b0; wr = 1'b0; zero = 1'b0; hlt = 1'b0;
    dhit = 1'b0; alu = 32'h0; adder = 32'h0; rdat2 = 32'h0; pcn = 32'h0;
    dload = 32'h0; wsel = 5'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    set_idle();
    #2;
    check_all("reset");
    @(negedge CLK);
    nRST = 1'b1;
    tick();
  endtask

  typedef struct {
    logic        rd, wr, br, zero, dhit;
    logic [31:0] addr, adder;
    logic        e_ren, e_wen, e_stall, e_bt;
  } vec_t;

  vec_t tbl[8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0048, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0050, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};

    set_idle();
    nRST = 1'b1;
    #3 nRST = 1'b0;
    #4;
    cmp("rst.wb_RegWrite", o_rw, 1'b0);
    cmp("rst.halt_out", o_halt, 1'b0);
    cmp("rst.mem_wait_cnt", o_cnt, 32'h0);
    cmp("rst.wb_load", o_load, 32'h0);
    check_all("rst");
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // single-cycle load
    rd = 1'b1; alu = 32'h0000_0040; dload = 32'hDEAD_BEEF; dhit = 1'b1;
    mtr = 2'b01; rw = 1'b1; wsel = 5'd7; pcn = 32'h0000_1004;
    @(negedge CLK);
    cmp("ld.dmemREN", ren, 1'b1);
    cmp("ld.mem_stall", stall, 1'b0);
    check_all("ld");
    tick();
    set_idle();
    @(negedge CLK);
    cmp("ld.wb_load", o_load, 32'hDEAD_BEEF);
    cmp("ld.wb_MemToReg", o_mtr, 2'b01);
    cmp("ld.wb_RegWrite", o_rw, 1'b1);
    check_all("ld2");
    tick();

    // store completing after three wait cycles
    wr = 1'b1; rdat2 = 32'h1234_5678; alu = 32'h0000_0080; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      cmp("st.dmemWEN", wen, 1'b1);
      cmp("st.mem_stall", stall, 1'b1);
      check_all("st");
      tick();
      cmp("st.bubble", o_rw, 1'b0);
    end
    dhit = 1'b1;
    @(negedge CLK);
    cmp("st.done_stall", stall, 1'b0);
    cmp("st.mem_wait_cnt", o_cnt, 32'd3);
    check_all("st_done");
    tick();
    set_idle();

    // directed table
    for (int i = 0; i < 8; i++) begin
      rd = tbl[i].rd; wr = tbl[i].wr; br = tbl[i].br; zero = tbl[i].zero;
      dhit = tbl[i].dhit; alu = tbl[i].addr; adder = tbl[i].adder;
      @(negedge CLK);
      cmp($sformatf("tbl%0d.ren", i), ren, tbl[i].e_ren);
      cmp($sformatf("tbl%0d.wen", i), wen, tbl[i].e_wen);
      cmp($sformatf("tbl%0d.stall", i), stall, tbl[i].e_stall);
      cmp($sformatf("tbl%0d.bt", i), bt, tbl[i].e_bt);
      cmp($sformatf("tbl%0d.flush", i), flush, tbl[i].e_bt);
      check_all($sformatf("tbl%0d", i));
      tick();
    end
    set_idle();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      rd = ($urandom_range(0, 2) == 0); wr = ($urandom_range(0, 3) == 0);
      br = $urandom_range(0, 1); zero = $urandom_range(0, 1);
      dhit = ($urandom_range(0, 2) != 0); rw = $urandom_range(0, 1);
      mtr = 2'($urandom_range(0, 2)); wsel = 5'($urandom);
      alu = $urandom; adder = $urandom; rdat2 = $urandom; pcn = $urandom; dload = $urandom;
      @(negedge CLK);
      check_all("rnd");
      tick();
    end
    set_idle();

    // reset while a load waits
    do_reset();
    rd = 1'b1; alu = 32'h0000_00C0; dhit = 1'b0; rw = 1'b1; mtr = 2'b01;
    @(negedge CLK);
    cmp("rw.stall", stall, 1'b1);
    tick();
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    cmp("rw.dmemREN", ren, 1'b0);
    cmp("rw.wb_RegWrite", o_rw, 1'b0);
    cmp("rw.mem_wait_cnt", o_cnt, 32'h0);
    check_all("rw");
    set_idle();
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    @(negedge CLK);
    cmp("rw.no_reissue", ren, 1'b0);
    tick();

    // counter saturation (4-bit instance)
    rd = 1'b1; dhit = 1'b0; alu = 32'h0000_0100;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check_all("sat");
      tick();
    end
    cmp("sat.cnt4", s4_cnt, 4'hF);
    cmp("sat.cnt32", o_cnt, 32'd20);
    dhit = 1'b1;
    tick();
    set_idle();

    // halt, then a load and a branch that must be ignored
    hlt = 1'b1; rw = 1'b1; alu = 32'h0000_0AAA; pcn = 32'h0000_2000;
    @(negedge CLK);
    check_all("hlt");
    tick();
    cmp("hlt.set", o_halt, 1'b1);
    set_idle();
    rd = 1'b1; dhit = 1'b0; br = 1'b1; zero = 1'b1; rw = 1'b1;
    alu = 32'h0000_0BBB; pcn = 32'h0000_3000; dload = 32'hCAFE_F00D;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      cmp("hlt.dmemREN", ren, 1'b0);
      cmp("hlt.branch_taken", bt, 1'b0);
      cmp("hlt.halt_out", o_halt, 1'b1);
      cmp("hlt.wb_alu", o_alu, 32'h0000_0AAA);
      check_all("hlt_frozen");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
